mesh_router: RTL



---
 rtl/mesh_router_pkg.sv | 53 +++++
 rtl/mesh_router_if.sv | 35 +++
 rtl/mesh_router_fifo.sv | 81 ++++++++
 rtl/mesh_router.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mesh_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mesh_router_pkg
// Purpose  : Shared types and helpers for the mesh router node: port
//            enumeration, route result record and the XY route function.
// Revision : 1.0 - initial release
// ============================================================================
package mesh_router_pkg;

    localparam int NUM_PORTS = 5;

    // Port order used on every vector in the router.
    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        EAST  = 3'd1,
        WEST  = 3'd2,
        NORTH = 3'd3,
        SOUTH = 3'd4
    } port_e;

    typedef struct packed {
        logic  drop;
        port_e port;
    } route_t;

    // Dimension-order routing: X is resolved first, then Y, then the flit
    // is delivered locally. Destinations outside the mesh are flagged for
    // dropping; the port field is then irrelevant.
    function automatic route_t route_xy(
        input int unsigned dx,
        input int unsigned dy,
        input int unsigned src_x,
        input int unsigned src_y,
        input int unsigned x_cnt,
        input int unsigned y_cnt
    );
        route_t r;
        r.drop = (dx >= x_cnt) || (dy >= y_cnt);
        r.port = LOCAL;
        if (dx > src_x) begin
            r.port = EAST;
        end else if (dx < src_x) begin
            r.port = WEST;
        end else if (dy > src_y) begin
            r.port = NORTH;
        end else if (dy < src_y) begin
            r.port = SOUTH;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_router_if.sv
`default_nettype none
// ============================================================================
// Module   : mesh_router_if
// Purpose  : Bundles the five input and five output req/ack/data channels
//            of one router node.
// Ports    : req_i/ack_i/data_i - input channels (router is the sink)
//            req_o/ack_o/data_o - output channels (router is the source)
//            modport slave  - router view
//            modport master - tile / environment view
// Revision : 1.0 - initial release
// ============================================================================
interface mesh_router_if #(
    parameter int PKT_W = 36
) ();
    import mesh_router_pkg::*;

    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS-1:0]            ack_i;
    logic [NUM_PORTS-1:0][PKT_W-1:0] data_i;
    logic [NUM_PORTS-1:0]            req_o;
    logic [NUM_PORTS-1:0]            ack_o;
    logic [NUM_PORTS-1:0][PKT_W-1:0] data_o;

    modport slave (
        input  req_i, data_i, ack_o,
        output ack_i, req_o, data_o
    );

    modport master (
        output req_i, data_i, ack_o,
        input  ack_i, req_o, data_o
    );

endinterface
`default_nettype wire

// File: rtl/mesh_router_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mesh_router_fifo
// Purpose  : Synchronous first-word-fall-through FIFO used as the input
//            buffer of each router port.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            push, din     - write strobe and data (ignored when full)
//            pop           - read strobe (ignored when empty)
//            dout          - current head entry
//            full, empty   - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module mesh_router_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [AW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [AW:0]      r_count_q,  w_count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count_q == C_FULL);
    assign empty     = (r_count_q == '0);
    assign dout      = r_mem_q[r_rd_ptr_q];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage is not reset: the occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesh_router.sv
`default_nettype none
// ============================================================================
// Module   : mesh_router
// Purpose  : 5-port mesh router node. Input FIFO per port, XY routing of
//            the head flit, per-output round-robin arbitration into a single
//            output register, and saturating accounting of flits whose
//            destination lies outside the mesh.
// Ports    : clk       - clock, all state on rising edge
//            rst       - synchronous active-high reset
//            bus       - mesh_router_if.slave: req_i/ack_i/data_i inputs,
//                        req_o/ack_o/data_o outputs (order L,E,W,N,S)
//            drop_cnt  - saturating count of dropped flits
// Revision : 1.0 - initial release
// ============================================================================
module mesh_router
    import mesh_router_pkg::*;
#(
    parameter int  PAYLOAD     = 32,
    parameter int  X_BITS      = 2,
    parameter int  Y_BITS      = 2,
    parameter int  X_CNT       = 4,
    parameter int  Y_CNT       = 4,
    parameter int  SRC_X       = 0,
    parameter int  SRC_Y       = 0,
    parameter int  FIFO_DEPTH  = 4,
    localparam int packet_size = X_BITS + Y_BITS + PAYLOAD
) (
    input  logic                clk,
    input  logic                rst,
    mesh_router_if.slave        bus,
    output logic [7:0]          drop_cnt
);

    logic [NUM_PORTS-1:0][packet_size-1:0] w_head;
    logic [NUM_PORTS-1:0]                  w_full;
    logic [NUM_PORTS-1:0]                  w_empty;
    logic [NUM_PORTS-1:0]                  w_push;
    logic [NUM_PORTS-1:0]                  w_pop;
    logic [NUM_PORTS-1:0]                  w_drop;
    route_t                                w_route [NUM_PORTS];
    // w_want[out][in]: input head is valid, routable and targets this output
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   w_want;
    // w_gnt_by_out[out][in]: grant issued by each output arbiter
    logic [NUM_PORTS-1:0]                  w_gnt_by_out [NUM_PORTS];

    logic [7:0] r_drop_cnt_q, w_drop_cnt_d;
    logic [8:0] w_drop_sum;

    // ------------------------------------------------------------------
    // Input side: buffering and route computation per port
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        assign bus.ack_i[p] = !w_full[p] && !rst;
        assign w_push[p]    = bus.req_i[p] && bus.ack_i[p];

        mesh_router_fifo #(
            .WIDTH (packet_size),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[p]),
            .pop   (w_pop[p]),
            .din   (bus.data_i[p]),
            .dout  (w_head[p]),
            .full  (w_full[p]),
            .empty (w_empty[p])
        );

        assign w_route[p] = route_xy(
            32'(w_head[p][packet_size-1 -: X_BITS]),
            32'(w_head[p][PAYLOAD +: Y_BITS]),
            SRC_X, SRC_Y, X_CNT, Y_CNT);
    end

    always_comb begin
        w_drop = '0;
        w_want = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_drop[p] = !w_empty[p] && w_route[p].drop;
            for (int o = 0; o < NUM_PORTS; o++) begin
                w_want[o][p] = !w_empty[p] && !w_route[p].drop
                               && (w_route[p].port == port_e'(o));
            end
        end
    end

    // A head leaves its FIFO either because it is dropped or because an
    // output granted it. Each head targets a single output, so at most one
    // grant per input can be set.
    always_comb begin
        w_pop = w_drop;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                w_pop[p] = w_pop[p] | w_gnt_by_out[o][p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output side: round-robin arbiter and output register per port
    // ------------------------------------------------------------------
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic                   r_valid_q, w_valid_d;
        logic [packet_size-1:0] r_data_q,  w_data_d;
        // r_ptr_q holds the input with highest priority (last grant + 1)
        logic [2:0]             r_ptr_q,   w_ptr_d;
        logic                   w_free;
        logic                   w_found;
        logic [2:0]             w_idx;
        logic [2:0]             w_sel;
        logic [NUM_PORTS-1:0]   w_gnt;

        always_comb begin
            // Free when empty or when the current flit is leaving this
            // cycle, which allows back-to-back streaming.
            w_free    = !r_valid_q || bus.ack_o[o];
            w_found   = 1'b0;
            w_idx     = '0;
            w_sel     = '0;
            w_gnt     = '0;
            w_ptr_d   = r_ptr_q;
            w_valid_d = r_valid_q;
            w_data_d  = r_data_q;

            for (int k = 0; k < NUM_PORTS; k++) begin
                w_idx = 3'((int'(r_ptr_q) + k) % NUM_PORTS);
                if (!w_found && w_free && w_want[o][w_idx]) begin
                    w_found = 1'b1;
                    w_sel   = w_idx;
                end
            end

            if (w_found) begin
                w_gnt[w_sel] = 1'b1;
                w_ptr_d      = (w_sel == 3'(NUM_PORTS - 1)) ? 3'd0 : w_sel + 3'd1;
            end

            if (w_free) begin
                w_valid_d = w_found;
                if (w_found) begin
                    w_data_d = w_head[w_sel];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
                r_ptr_q   <= '0;
            end else begin
                r_valid_q <= w_valid_d;
                r_data_q  <= w_data_d;
                r_ptr_q   <= w_ptr_d;
            end
        end

        assign w_gnt_by_out[o] = w_gnt;
        assign bus.req_o[o]    = r_valid_q;
        assign bus.data_o[o]   = r_data_q;
    end

    // ------------------------------------------------------------------
    // Drop accounting: several inputs may drop in the same cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt_q};
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_drop_sum = w_drop_sum + 9'(w_drop[p]);
        end
        w_drop_cnt_d = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt_q <= '0;
        end else begin
            r_drop_cnt_q <= w_drop_cnt_d;
        end
    end

    assign drop_cnt = r_drop_cnt_q;

endmodule
`default_nettype wire
